// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - FPU issue/writeback sequencer: latches one op, holds it on the FPU until fin, presents the result to writeback
module fpu_issue #(
  parameter logic [3:0] IDLE_OP    = 4'b0101,
  parameter int         MAX_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src0,
  input  logic [31:0] req_src1,
  input  logic [4:0]  req_rd,
  output logic [31:0] fpu_src0,
  output logic [31:0] fpu_src1,
  output logic [3:0]  fpu_op,
  input  logic [31:0] fpu_result,
  input  logic        fpu_fin,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_to_int,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [31:0]   src0_q;
  logic [31:0]   src1_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;
  logic          op_is_int;

  // feq/flt/fle/fcvt.w.s write the integer register file
  assign op_is_int = (op_q == 4'b1000) || (op_q == 4'b1001) ||
                     (op_q == 4'b1010) || (op_q == 4'b1011);

  assign req_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  // Outside EXEC a single-cycle op keeps the FPU latency counter parked at 0
  assign fpu_op    = (state == S_EXEC) ? op_q : IDLE_OP;
  assign fpu_src0  = src0_q;
  assign fpu_src1  = src1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= 4'd0;
      src0_q      <= 32'd0;
      src1_q      <= 32'd0;
      rd_q        <= 5'd0;
      cnt         <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= 32'd0;
      wb_rd       <= 5'd0;
      wb_to_int   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            src0_q <= req_src0;
            src1_q <= req_src1;
            rd_q   <= req_rd;
            cnt    <= '0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
          if (fpu_fin) begin
            wb_data   <= fpu_result;
            wb_rd     <= rd_q;
            wb_to_int <= op_is_int;
            wb_valid  <= 1'b1;
            state     <= S_HOLD;
          end else if (cnt == CNT_LAST) begin
            wb_data     <= 32'd0;
            wb_valid    <= 1'b1;
            timeout_err <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - scoreboard bench for fpu_issue with a behavioural FPU stub
module tb_fpu_issue;

  localparam logic [3:0] IDLE_OP = 4'b0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_src0 = 32'd0;
  logic [31:0] req_src1 = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] fpu_src0, fpu_src1, fpu_result;
  logic [3:0]  fpu_op;
  logic        fpu_fin;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_to_int, busy, timeout_err;

  fpu_issue #(.IDLE_OP(IDLE_OP), .MAX_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src0(req_src0), .req_src1(req_src1), .req_rd(req_rd),
    .fpu_src0(fpu_src0), .fpu_src1(fpu_src1), .fpu_op(fpu_op),
    .fpu_result(fpu_result), .fpu_fin(fpu_fin),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_to_int(wb_to_int), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Extra cycles the FPU needs beyond the first one, by opcode
  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010: return 3;
      4'b0011:                   return 11;
      4'b0100:                   return 8;
      4'b1011, 4'b1100:          return 1;
      default:                   return 0;
    endcase
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mix;
    mix = a ^ {b[15:0], b[31:16]} ^ {28'h0, op};
    case (op)
      4'b0000: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : mix;
      4'b0011: return (a == 32'h40C00000 && b == 32'h40000000) ? 32'h40400000 : mix;
      4'b0101: return {b[31], a[30:0]};
      4'b0110: return {~b[31], a[30:0]};
      4'b0111: return {a[31] ^ b[31], a[30:0]};
      4'b1000: return {31'd0, a == b};
      4'b1001: return {31'd0, $signed(a) < $signed(b)};
      4'b1010: return {31'd0, $signed(a) <= $signed(b)};
      4'b1100: return (a == 32'd3) ? 32'h40400000 : mix;
      4'b1101, 4'b1110, 4'b1111: return 32'd0;
      default: return mix;
    endcase
  endfunction

  // FPU stub: fin is combinational once its counter reaches the op latency
  logic [4:0] fcnt = 5'd0;
  bit         stuck = 1'b0;
  assign fpu_fin    = !stuck && (fcnt == 5'(lat_of(fpu_op)));
  assign fpu_result = fpu_calc(fpu_op, fpu_src0, fpu_src1);
  always @(posedge clk) begin
    if (rst || fpu_fin || stuck) fcnt <= 5'd0;
    else                         fcnt <= fcnt + 5'd1;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s0, s1, data;
    logic [4:0]  rd;
    logic        to_int, tmo, terr;
    int          lat, acc;
  } exp_t;

  exp_t sbq[$];
  bit   sticky_m = 1'b0;
  int   bp_mode = 2;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode == 0) wb_ready = ($urandom % 3) != 0;
      else              wb_ready = (bp_mode == 2);
    end
  end

  // Monitor: latency on wb_valid rise, content on handshake, stability in HOLD
  bit          prev_v = 1'b0;
  logic [31:0] prev_data = 32'd0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (busy && !wb_valid && sbq.size() > 0) begin
        chk("exec_fpu_op", {28'd0, fpu_op}, {28'd0, sbq[0].op});
        chk("exec_src0", fpu_src0, sbq[0].s0);
        chk("exec_src1", fpu_src1, sbq[0].s1);
      end
      if (wb_valid && !prev_v) begin
        if (sbq.size() == 0) chk("wb_spurious", 32'd1, 32'd0);
        else chk("wb_latency", cyc - sbq[0].acc, sbq[0].lat);
      end
      if (wb_valid && prev_v) begin
        chk("hold_data_stable", wb_data, prev_data);
        chk("hold_fpu_op", {28'd0, fpu_op}, {28'd0, IDLE_OP});
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      if (wb_valid && wb_ready && sbq.size() > 0) begin
        chk("wb_data", wb_data, sbq[0].data);
        if (!sbq[0].tmo) begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, sbq[0].rd});
          chk("wb_to_int", {31'd0, wb_to_int}, {31'd0, sbq[0].to_int});
        end
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, sbq[0].terr});
        void'(sbq.pop_front());
      end
      prev_v    = wb_valid;
      prev_data = wb_data;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit dir, input logic [31:0] dd,
                       input int dl, input bit tmo);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_src0 = a; req_src1 = b; req_rd = rd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("req_accept_bound", 32'd0, 32'd1);
    end else begin
      if (tmo) sticky_m = 1'b1;
      e.op = op; e.s0 = a; e.s1 = b; e.rd = rd; e.tmo = tmo; e.terr = sticky_m;
      e.to_int = (op >= 4'b1000) && (op <= 4'b1011);
      e.data   = dir ? dd : fpu_calc(op, a, b);
      e.lat    = dir ? dl : 2 + lat_of(op);
      e.acc    = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_src0 = $urandom; req_src1 = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || busy) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (sbq.size() != 0 || busy) chk("drain_bound", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_to_int", {31'd0, wb_to_int}, 32'd0);
    chk("rst_fpu_op", {28'd0, fpu_op}, {28'd0, IDLE_OP});
    @(posedge clk); #1 rst = 1'b0;

    // fsgnj, then fadd with the ready-again check one cycle after the handshake
    issue(4'b0101, 32'h3F800000, 32'hBF800000, 5'd3, 1'b1, 32'hBF800000, 2, 1'b0);
    wait_idle();
    issue(4'b0000, 32'h3F800000, 32'h40000000, 5'd9, 1'b1, 32'h40400000, 5, 1'b0);
    begin
      int n = 0;
      while (!(wb_valid && wb_ready) && n < 50) begin n++; @(negedge clk); end
      @(negedge clk);
      chk("ready_after_wb", {31'd0, req_ready}, 32'd1);
    end
    wait_idle();

    // fdiv held under backpressure
    bp_mode = 1;
    issue(4'b0011, 32'h40C00000, 32'h40000000, 5'd12, 1'b1, 32'h40400000, 13, 1'b0);
    repeat (20) @(negedge clk);
    chk("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("bp_wb_data", wb_data, 32'h40400000);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    bp_mode = 2;
    wait_idle();

    // feq into the integer file, then back-to-back fcvt.s.w
    issue(4'b1000, 32'h3F800000, 32'h3F800000, 5'd7, 1'b1, 32'h00000001, 2, 1'b0);
    issue(4'b1100, 32'h00000003, 32'h00000000, 5'd4, 1'b1, 32'h40400000, 3, 1'b0);
    wait_idle();

    // Timeout with fin stuck low, then sticky flag across a normal op
    stuck = 1'b1;
    issue(4'b0010, $urandom, $urandom, 5'd5, 1'b1, 32'd0, 17, 1'b1);
    wait_idle();
    stuck = 1'b0;
    issue(4'b0111, 32'h12345678, 32'h87654321, 5'd6, 1'b0, 32'd0, 0, 1'b0);
    wait_idle();
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of an fdiv
    issue(4'b0011, 32'h40C00000, 32'h40000000, 5'd15, 1'b0, 32'd0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sbq.delete();
    sticky_m = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    issue(4'b0000, 32'h3F800000, 32'h40000000, 5'd21, 1'b1, 32'h40400000, 5, 1'b0);
    wait_idle();

    // Randomized traffic with random backpressure and request gaps
    bp_mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'b0, 32'd0, 0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    bp_mode = 2;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
Issue/writeback sequencer directly upstream of the FPU. It accepts one float operation per valid/ready handshake, latches the operands, and holds op and sources stable on the FPU inputs until the FPU raises fin. It captures the result and presents it to the writeback stage with valid/ready, tagged with destination register and int/float register-file select. It also keeps the FPU's internal latency counter from free-running while idle.

Parameters:
IDLE_OP, 4'b0101, op driven to the FPU when no operation is in flight. Must be a single-cycle op so the FPU latency counter stays at 0.
MAX_CYCLES, 16, EXEC-cycle limit before timeout (2..255).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high; the FPU's rstn is tied to ~rst at top level
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  4  FPU opcode (0000 fadd … 1100 fcvt.s.w)
req_src0  in  32  operand 0
req_src1  in  32  operand 1
req_rd  in  5  destination register
fpu_src0  out  32  to FPU src0
fpu_src1  out  32  to FPU src1
fpu_op  out  4  to FPU fpuop
fpu_result  in  32  from FPU result
fpu_fin  in  1  from FPU fin
wb_valid  out  1  result valid
wb_ready  in  1  writeback accepts
wb_data  out  32  result
wb_rd  out  5  destination register
wb_to_int  out  1  1 = integer register file destination
busy  out  1  operation in flight (state != IDLE)
timeout_err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, EXEC, HOLD. Reset: state=IDLE; wb_valid=0; busy=0; timeout_err=0; wb_data, wb_rd, wb_to_int = 0; cycle counter = 0.
- req_ready = (state==IDLE) && !rst. It is combinational from state only and never depends on req_valid.
- IDLE:
  - fpu_op = IDLE_OP; fpu_src0 and fpu_src1 = latched registers (don't-care).
  - On req_valid&req_ready: latch op, src0, src1, rd; clear counter; go to EXEC.
- EXEC:
  - fpu_op, fpu_src0, fpu_src1 = latched values, constant for the whole state.
  - Counter increments each cycle.
  - If fpu_fin=1: wb_data<=fpu_result; wb_rd<=latched rd; wb_to_int<=(op in {1000,1001,1010,1011}); wb_valid<=1; go to HOLD.
  - Else, if counter reaches MAX_CYCLES-1: wb_data<=0; wb_valid<=1; timeout_err<=1; go to HOLD.
  - fin has priority over timeout in the same cycle.
- HOLD:
  - fpu_op = IDLE_OP. The FPU has already cleared its counter on the fin cycle; driving a multi-cycle op here would restart it.
  - wb_valid held with wb_data, wb_rd, wb_to_int stable until wb_ready=1. On that handshake: wb_valid<=0; go to IDLE.
- Latency: request accepted at cycle T gives wb_valid high at T+2+N. N=0 for fsgnj/fsgnjn/fsgnjx/feq/fle/flt/invalid, 1 for fcvt.w.s/fcvt.s.w, 3 for fadd/fsub/fmul, 8 for fsqrt, 11 for fdiv.
- Throughput: one op in flight. Next accept is the cycle after the wb handshake (HOLD→IDLE→accept).
- Invalid opcodes 1101–1111 pass through: the FPU gives fin=1 and result 0, so wb_data=0 and wb_to_int=0. No error is flagged.
- wb_ready=1 while wb_valid=0 is ignored. req_valid outside IDLE is ignored and no request is latched.
- timeout_err is sticky; it clears only on rst.
- rst mid-operation (any state): return to the reset values next edge. The in-flight op and any pending wb result are discarded. The FPU is reset by the same signal.
- Counter width: ceil(log2(MAX_CYCLES)) bits. It saturates and does not wrap.

Test Plan:
- fsgnj: op 0101, src0=3F800000, src1=BF800000, accepted at T -> wb_valid at T+2, wb_data=BF800000, wb_to_int=0, wb_rd=req_rd.
- fadd: op 0000, src0=3F800000, src1=40000000, wb_ready=1 -> wb_valid at T+5, wb_data=40400000. Next req_ready at T+6. fpu_op=0101 in HOLD.
- fdiv with backpressure: op 0011, src0=40C00000, src1=40000000, wb_ready=0 for 20 cycles -> wb_valid at T+13, held with wb_data=40400000 until wb_ready. req_ready=0 and fpu_op=0101 throughout HOLD.
- feq to integer register: op 1000, src0=src1=3F800000, rd=7 -> wb_data=00000001, wb_to_int=1, wb_rd=7. Back-to-back fcvt.s.w: op 1100, src0=00000003 -> wb_data=40400000, wb_to_int=0, wb_valid at T+3.
- Timeout: stub FPU with fin stuck 0, MAX_CYCLES=16 -> wb_valid at T+17 with wb_data=0, timeout_err=1 and still 1 after the next normal op.
- Reset mid-fdiv: rst pulsed at T+5 -> next cycle busy=0, wb_valid=0, req_ready=1 after rst drops. A following fadd completes at the normal latency with the correct result.
